l2_noc1_req_injector: RTL and testbench
=======================================

// Module: l2_noc1_req_injector
// PURPOSE
//  Upstream stimulus stage for L2 request-path verification and simulation.
//  Accepts one abstract request (type, MSHR tag, address, source, optional data word) and serialises it into
//  64-bit NoC1 flits driven into the L2's noc1 input.
//  Pulses issue/accept markers that the L2 pipeline monitors use to start tracking the request.
//  Has a stall watchdog.
// PARAMETERS
//  TIMEOUT_CYCLES  64  consecutive cycles with flit pending and noc1_ready low before stall_timeout sets
//  ADDR_W          40  physical address width carried in the address flit
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  req_valid       in   1   request offered
//  req_ready       out  1   request accepted when req_valid & req_ready
//  req_type        in   8   message type (e.g. STORE_REQ, LOAD_REQ)
//  req_mshrid      in   8   requester MSHR tag
//  req_addr        in   ADDR_W  line address
//  req_dst_chipid  in   14  destination chip id
//  req_dst_x       in   8   destination tile x
//  req_dst_y       in   8   destination tile y
//  req_src_x       in   8   source tile x
//  req_src_y       in   8   source tile y
//  req_has_data    in   1   append one data flit (stores)
//  req_data        in   64  data word
//  noc1_data       out  64  flit to L2 noc1_data_in
//  noc1_valid      out  1   flit valid
//  noc1_ready      in   1   L2 noc1_ready_in
//  issue_pulse     out  1   one-cycle pulse when header flit handshakes
//  done_pulse      out  1   one-cycle pulse when last flit handshakes
//  busy            out  1   message in flight
//  stall_timeout   out  1   sticky watchdog flag
// BEHAVIOUR
//  Reset values: all outputs 0 except req_ready=1; FSM=IDLE; counters 0.
//  FSM states:
//   - IDLE: req_ready=1. On accept, latch all req_* fields and go to HDR. No flit is driven in the accept cycle.
//   - HDR, ADDR, SRC, DATA: noc1_valid=1. Advance only on noc1_valid & noc1_ready.
//   - Transitions: HDR->ADDR->SRC; then SRC->DATA if has_data, else SRC->IDLE; DATA->IDLE.
//  Flit formats:
//   - HDR:  [63:50] dst_chipid, [49:42] dst_x, [41:34] dst_y, [33:30] 4'b0, [29:22] payload length
//     (2 + has_data), [21:14] type, [13:6] mshrid, [5:0] 0.
//   - ADDR: [63:ADDR_W] 0, [ADDR_W-1:0] addr.
//   - SRC:  [63:50] dst_chipid, [49:42] src_x, [41:34] src_y, rest 0.
//   - DATA: req_data verbatim.
//  noc1_data and noc1_valid are registered and held stable while noc1_ready=0. noc1_data=0 whenever noc1_valid=0.
//  Back-to-back: on the last-flit handshake, return to IDLE. The next accept occurs the following cycle,
//  giving a minimum 1-cycle bubble between messages.
//  issue_pulse is asserted in the cycle of the HDR handshake. done_pulse is asserted in the cycle of the
//  last-flit handshake. Both may coincide only if a 1-flit mode is added later (not now).
//  busy = (state != IDLE).
//  Watchdog:
//   - An 8-bit-or-wider counter increments while noc1_valid & ~noc1_ready and clears on any handshake.
//   - When the counter reaches TIMEOUT_CYCLES, stall_timeout sets and stays set until rst.
//   - The counter saturates; it never wraps.
//  rst mid-message: abandon the message immediately, drop noc1_valid the next cycle, emit no pulses.
//  Inputs are ignored outside IDLE; fields are sampled only at accept.
// STRUCTURE
//  Shared package l2_noc_pkg:
//   - msg type localparams (STORE_REQ, LOAD_REQ, ...)
//   - flit field offsets
//   - injector state enum
//  Sub-module l2_noc1_stall_watchdog holds the counter plus sticky flag. Everything else is flat.
// TESTING
//  1. Store, ready=1 always: type=STORE_REQ, addr=0x12_3456_7840, has_data=1, data=0xDEADBEEF_CAFEF00D
//     -> 4 consecutive flits (HDR len=3, ADDR, SRC, DATA); issue_pulse at flit 0; done_pulse at flit 3.
//  2. Load, no data -> exactly 3 flits with HDR len=2; state back to IDLE; req_ready=1 one cycle after done.
//  3. noc1_ready toggled 1,0,0,1 during ADDR -> ADDR flit held bit-identical for the 2 stall cycles;
//     no duplicate or lost flit.
//  4. noc1_ready held 0 for TIMEOUT_CYCLES cycles at HDR -> stall_timeout rises exactly then;
//     it stays 1 after ready returns.
//  5. rst asserted during the SRC flit -> the next cycle noc1_valid=0, busy=0, req_ready=1, and no done_pulse.
//  6. Two back-to-back requests with req_valid held -> second HDR follows first DATA after exactly
//     one idle cycle; mshrid fields differ correctly.

Source files
------------

// File: rtl/l2_noc_pkg.sv
// Shared NoC definitions for the L2 request-path injector: message types,
// flit field offsets and the injector state enum.
package l2_noc_pkg;

    localparam int unsigned FlitW = 64;

    localparam logic [7:0] PREFETCH_REQ      = 8'd1;
    localparam logic [7:0] STORE_REQ         = 8'd2;
    localparam logic [7:0] BLK_STORE_REQ     = 8'd3;
    localparam logic [7:0] BLKINIT_STORE_REQ = 8'd4;
    localparam logic [7:0] CAS_REQ           = 8'd5;
    localparam logic [7:0] LOAD_REQ          = 8'd31;

    localparam int unsigned HdrChipidLsb = 50;
    localparam int unsigned HdrXLsb      = 42;
    localparam int unsigned HdrYLsb      = 34;
    localparam int unsigned HdrLenLsb    = 22;
    localparam int unsigned HdrTypeLsb   = 14;
    localparam int unsigned HdrMshrLsb   = 6;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StAddr,
        StSrc,
        StData
    } inj_state_e;

    function automatic logic [FlitW-1:0] build_hdr(
        input logic [13:0] chipid,
        input logic [7:0]  x,
        input logic [7:0]  y,
        input logic [7:0]  len,
        input logic [7:0]  msg_type,
        input logic [7:0]  mshrid
    );
        logic [FlitW-1:0] f;
        f = '0;
        f[HdrChipidLsb +: 14] = chipid;
        f[HdrXLsb +: 8]       = x;
        f[HdrYLsb +: 8]       = y;
        f[HdrLenLsb +: 8]     = len;
        f[HdrTypeLsb +: 8]    = msg_type;
        f[HdrMshrLsb +: 8]    = mshrid;
        return f;
    endfunction

    // Source flit reuses the header's chip/x/y slots for the requester location.
    function automatic logic [FlitW-1:0] build_src(
        input logic [13:0] chipid,
        input logic [7:0]  x,
        input logic [7:0]  y
    );
        logic [FlitW-1:0] f;
        f = '0;
        f[HdrChipidLsb +: 14] = chipid;
        f[HdrXLsb +: 8]       = x;
        f[HdrYLsb +: 8]       = y;
        return f;
    endfunction

endpackage

// File: rtl/l2_noc1_stall_watchdog.sv
// Counts consecutive stalled flit cycles and raises a sticky flag once the
// count reaches TIMEOUT_CYCLES.
module l2_noc1_stall_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    input  logic handshake_i,
    output logic stall_timeout_o
);

    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            flag_q, flag_d;

    always_comb begin
        cnt_d = cnt_q;
        if (handshake_i) begin
            cnt_d = '0;
        end else if (stall_i && (cnt_q != CntLimit)) begin
            cnt_d = cnt_q + 1'b1;
        end
        flag_d = flag_q | (cnt_d == CntLimit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign stall_timeout_o = flag_q;

endmodule

// File: rtl/l2_noc1_req_injector.sv
// Serialises one abstract L2 request into NoC1 flits (HDR, ADDR, SRC, optional
// DATA) with issue/done markers and a stall watchdog.
module l2_noc1_req_injector
    import l2_noc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned ADDR_W         = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_type,
    input  logic [7:0]        req_mshrid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [13:0]       req_dst_chipid,
    input  logic [7:0]        req_dst_x,
    input  logic [7:0]        req_dst_y,
    input  logic [7:0]        req_src_x,
    input  logic [7:0]        req_src_y,
    input  logic              req_has_data,
    input  logic [63:0]       req_data,
    output logic [63:0]       noc1_data,
    output logic              noc1_valid,
    input  logic              noc1_ready,
    output logic              issue_pulse,
    output logic              done_pulse,
    output logic              busy,
    output logic              stall_timeout
);

    inj_state_e state_q, state_d;

    logic [FlitW-1:0]  flit_q, flit_d;
    logic              valid_q, valid_d;
    logic [13:0]       chipid_q;
    logic [7:0]        src_x_q, src_y_q;
    logic [ADDR_W-1:0] addr_q;
    logic              has_data_q;
    logic [63:0]       data_q;

    logic accept;
    logic hs;
    logic last_flit;

    assign accept    = req_valid && (state_q == StIdle);
    assign hs        = valid_q && noc1_ready;
    assign last_flit = (state_q == StData) || ((state_q == StSrc) && !has_data_q);

    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
        valid_d = valid_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StHdr;
                    valid_d = 1'b1;
                    flit_d  = build_hdr(req_dst_chipid, req_dst_x, req_dst_y,
                                        8'd2 + {7'd0, req_has_data}, req_type, req_mshrid);
                end
            end
            StHdr: begin
                if (hs) begin
                    state_d = StAddr;
                    flit_d  = FlitW'(addr_q);
                end
            end
            StAddr: begin
                if (hs) begin
                    state_d = StSrc;
                    flit_d  = build_src(chipid_q, src_x_q, src_y_q);
                end
            end
            StSrc: begin
                if (hs) begin
                    if (has_data_q) begin
                        state_d = StData;
                        flit_d  = data_q;
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        flit_d  = '0;
                    end
                end
            end
            StData: begin
                if (hs) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    flit_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                flit_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            flit_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            valid_q <= valid_d;
        end
    end

    // Only the fields needed after the header flit are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            chipid_q   <= '0;
            src_x_q    <= '0;
            src_y_q    <= '0;
            addr_q     <= '0;
            has_data_q <= 1'b0;
            data_q     <= '0;
        end else if (accept) begin
            chipid_q   <= req_dst_chipid;
            src_x_q    <= req_src_x;
            src_y_q    <= req_src_y;
            addr_q     <= req_addr;
            has_data_q <= req_has_data;
            data_q     <= req_data;
        end
    end

    l2_noc1_stall_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (valid_q && !noc1_ready),
        .handshake_i    (hs),
        .stall_timeout_o(stall_timeout)
    );

    assign req_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign noc1_data   = flit_q;
    assign noc1_valid  = valid_q;
    // A handshake coinciding with rst is abandoned, so it must not be marked.
    assign issue_pulse = hs && (state_q == StHdr) && !rst;
    assign done_pulse  = hs && last_flit && !rst;

endmodule

// File: tb/tb_l2_noc1_req_injector.sv
// Scoreboard bench for l2_noc1_req_injector: directed cases plus randomized
// requests checked against a flit-level reference model.
module tb_l2_noc1_req_injector;
    import l2_noc_pkg::*;

    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned AW      = 40;

    typedef struct packed {
        logic [13:0]   chipid;
        logic [7:0]    dx;
        logic [7:0]    dy;
        logic [7:0]    sx;
        logic [7:0]    sy;
        logic [7:0]    typ;
        logic [7:0]    mshr;
        logic [AW-1:0] addr;
        logic          has_data;
        logic [63:0]   data;
    } req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        first;
        logic        last;
    } exp_t;

    logic          clk, rst;
    logic          req_valid, req_ready;
    logic [7:0]    req_type, req_mshrid;
    logic [AW-1:0] req_addr;
    logic [13:0]   req_dst_chipid;
    logic [7:0]    req_dst_x, req_dst_y, req_src_x, req_src_y;
    logic          req_has_data;
    logic [63:0]   req_data;
    logic [63:0]   noc1_data;
    logic          noc1_valid, noc1_ready;
    logic          issue_pulse, done_pulse, busy, stall_timeout;

    l2_noc1_req_injector #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .ADDR_W        (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_type      (req_type),
        .req_mshrid    (req_mshrid),
        .req_addr      (req_addr),
        .req_dst_chipid(req_dst_chipid),
        .req_dst_x     (req_dst_x),
        .req_dst_y     (req_dst_y),
        .req_src_x     (req_src_x),
        .req_src_y     (req_src_y),
        .req_has_data  (req_has_data),
        .req_data      (req_data),
        .noc1_data     (noc1_data),
        .noc1_valid    (noc1_valid),
        .noc1_ready    (noc1_ready),
        .issue_pulse   (issue_pulse),
        .done_pulse    (done_pulse),
        .busy          (busy),
        .stall_timeout (stall_timeout)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    req_t req_q[$];
    exp_t sb[$];
    int   issue_log[$];
    int   done_log[$];
    bit   pat[$];
    int   ready_mode  = 0;  // 0 constant, 1 random, 2 pattern while valid
    bit   ready_const = 1'b1;

    function automatic void chk(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: a request becomes 3 or 4 flits built from the field layout.
    function automatic void push_expected(input req_t r);
        logic [63:0] hdr, addr, src, len;
        len  = 64'd2 + 64'(r.has_data);
        hdr  = (64'(r.chipid) << 50) | (64'(r.dx) << 42) | (64'(r.dy) << 34) |
               (len << 22) | (64'(r.typ) << 14) | (64'(r.mshr) << 6);
        addr = 64'(r.addr);
        src  = (64'(r.chipid) << 50) | (64'(r.sx) << 42) | (64'(r.sy) << 34);
        sb.push_back('{data: hdr, first: 1'b1, last: 1'b0});
        sb.push_back('{data: addr, first: 1'b0, last: 1'b0});
        sb.push_back('{data: src, first: 1'b0, last: !r.has_data});
        if (r.has_data) sb.push_back('{data: r.data, first: 1'b0, last: 1'b1});
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.chipid   = 14'($urandom());
        r.dx       = 8'($urandom());
        r.dy       = 8'($urandom());
        r.sx       = 8'($urandom());
        r.sy       = 8'($urandom());
        r.typ      = ($urandom_range(0, 1) != 0) ? STORE_REQ : LOAD_REQ;
        r.mshr     = 8'($urandom());
        r.addr     = AW'({$urandom(), $urandom()});
        r.has_data = (r.typ == STORE_REQ);
        r.data     = {$urandom(), $urandom()};
        return r;
    endfunction

    function automatic req_t mk_req(input logic [7:0] typ, input logic [7:0] mshr,
                                    input logic [AW-1:0] addr, input logic [63:0] data);
        req_t r;
        r.chipid   = 14'h1A5;
        r.dx       = 8'h03;
        r.dy       = 8'h05;
        r.sx       = 8'h01;
        r.sy       = 8'h02;
        r.typ      = typ;
        r.mshr     = mshr;
        r.addr     = addr;
        r.has_data = (typ == STORE_REQ);
        r.data     = data;
        return r;
    endfunction

    task automatic drive_fields(input req_t r);
        req_dst_chipid = r.chipid;
        req_dst_x      = r.dx;
        req_dst_y      = r.dy;
        req_src_x      = r.sx;
        req_src_y      = r.sy;
        req_type       = r.typ;
        req_mshrid     = r.mshr;
        req_addr       = r.addr;
        req_has_data   = r.has_data;
        req_data       = r.data;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Request driver: fields are garbage whenever req_valid is low.
    initial begin
        req_valid = 1'b0;
        drive_fields(rand_req());
        forever begin
            @(negedge clk);
            if (!rst && req_valid && req_ready) begin
                push_expected(req_q[0]);
                void'(req_q.pop_front());
            end
            @(posedge clk);
            #1;
            if (req_q.size() > 0 && !rst) begin
                drive_fields(req_q[0]);
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
                drive_fields(rand_req());
            end
        end
    end

    initial begin
        noc1_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       noc1_ready = ready_const;
                1:       noc1_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (noc1_valid && pat.size() > 0) noc1_ready = pat.pop_front();
                    else noc1_ready = 1'b1;
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every flit handshake.
    initial begin
        bit          prev_stall, prev_done;
        logic [63:0] prev_data;
        exp_t        e;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk(!issue_pulse && !done_pulse, "pulse_in_rst",
                    64'({issue_pulse, done_pulse}), 64'd0);
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (prev_done)
                    chk(req_ready && !busy && !noc1_valid, "idle_after_done",
                        64'({req_ready, busy, noc1_valid}), 64'(3'b100));
                if (prev_stall)
                    chk(noc1_valid && noc1_data == prev_data, "hold_stable", noc1_data, prev_data);
                chk(busy == noc1_valid, "busy_vs_valid", 64'(busy), 64'(noc1_valid));
                chk(req_ready == !busy, "ready_vs_busy", 64'(req_ready), 64'(!busy));
                if (!noc1_valid) chk(noc1_data == 64'd0, "data_zero_idle", noc1_data, 64'd0);
                if (noc1_valid && noc1_ready) begin
                    chk(sb.size() != 0, "unexpected_flit", noc1_data, 64'd0);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk(noc1_data == e.data, "flit_data", noc1_data, e.data);
                        chk(issue_pulse == e.first, "issue_pulse", 64'(issue_pulse), 64'(e.first));
                        chk(done_pulse == e.last, "done_pulse", 64'(done_pulse), 64'(e.last));
                    end
                end else begin
                    chk(!issue_pulse && !done_pulse, "pulse_no_hs",
                        64'({issue_pulse, done_pulse}), 64'd0);
                end
                if (issue_pulse) issue_log.push_back(cyc);
                if (done_pulse) done_log.push_back(cyc);
                prev_stall = noc1_valid && !noc1_ready;
                prev_data  = noc1_data;
                prev_done  = done_pulse;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((req_q.size() > 0 || sb.size() > 0 || busy || req_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(n < budget, "idle_timeout", 64'(n), 64'(budget));
    endtask

    task automatic clear_logs();
        issue_log.delete();
        done_log.delete();
    endtask

    task automatic check_span(input string name, input int idx, input int exp_span);
        chk(issue_log.size() > idx && done_log.size() > idx, {name, "_count"},
            64'(done_log.size()), 64'(idx + 1));
        if (issue_log.size() > idx && done_log.size() > idx)
            chk(done_log[idx] - issue_log[idx] == exp_span, name,
                64'(done_log[idx] - issue_log[idx]), 64'(exp_span));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(req_ready == 1'b1, "rst_req_ready", 64'(req_ready), 64'd1);
        chk(noc1_valid == 1'b0 && noc1_data == 64'd0, "rst_noc1", noc1_data, 64'd0);
        chk(!busy && !stall_timeout, "rst_busy_wd", 64'({busy, stall_timeout}), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Store with ready always high: 4 back-to-back flits.
        clear_logs();
        req_q.push_back(mk_req(STORE_REQ, 8'h11, 40'h12_3456_7840, 64'hDEADBEEF_CAFEF00D));
        wait_idle(200);
        check_span("store_span", 0, 3);

        // Load: 3 flits.
        clear_logs();
        req_q.push_back(mk_req(LOAD_REQ, 8'h12, 40'hAB_CDEF_0100, 64'h0));
        wait_idle(200);
        check_span("load_span", 0, 2);

        // Two-cycle stall on the ADDR flit.
        clear_logs();
        pat.delete();
        pat.push_back(1'b1);
        pat.push_back(1'b0);
        pat.push_back(1'b0);
        pat.push_back(1'b1);
        ready_mode = 2;
        req_q.push_back(mk_req(LOAD_REQ, 8'h13, 40'h00_0000_1FC0, 64'h0));
        wait_idle(200);
        check_span("addr_stall_span", 0, 4);

        // Watchdog: header held off for exactly TIMEOUT cycles.
        ready_mode  = 0;
        ready_const = 1'b0;
        req_q.push_back(mk_req(LOAD_REQ, 8'h14, 40'h55_5555_5540, 64'h0));
        n = 0;
        while (!noc1_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(noc1_valid == 1'b1, "wd_hdr_seen", 64'(noc1_valid), 64'd1);
        chk(stall_timeout == 1'b0, "wd_start", 64'(stall_timeout), 64'd0);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk(stall_timeout == 1'b0, "wd_before_limit", 64'(stall_timeout), 64'd0);
        @(negedge clk);
        chk(stall_timeout == 1'b1, "wd_at_limit", 64'(stall_timeout), 64'd1);
        ready_const = 1'b1;
        wait_idle(200);
        chk(stall_timeout == 1'b1, "wd_sticky", 64'(stall_timeout), 64'd1);

        // Reset while SRC is about to handshake.
        pat.delete();
        pat.push_back(1'b1);
        pat.push_back(1'b1);
        pat.push_back(1'b0);
        pat.push_back(1'b1);
        ready_mode = 2;
        req_q.push_back(mk_req(LOAD_REQ, 8'h15, 40'h0F_0F0F_0F00, 64'h0));
        n = 0;
        while (!(noc1_valid && !noc1_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(n < 50, "rst_src_reached", 64'(n), 64'd50);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk(noc1_valid && noc1_ready, "rst_cycle_hs_offered", 64'({noc1_valid, noc1_ready}), 64'd3);
        chk(done_pulse == 1'b0, "rst_no_done", 64'(done_pulse), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk(!noc1_valid && !busy && req_ready, "rst_abandon",
            64'({noc1_valid, busy, req_ready}), 64'd1);
        chk(stall_timeout == 1'b0, "rst_clears_wd", 64'(stall_timeout), 64'd0);
        sb.delete();
        ready_mode  = 0;
        ready_const = 1'b1;

        // Back-to-back with req_valid held across the gap.
        clear_logs();
        req_q.push_back(mk_req(STORE_REQ, 8'h21, 40'h11_2233_4400, 64'h0123_4567_89AB_CDEF));
        req_q.push_back(mk_req(LOAD_REQ, 8'h22, 40'h11_2233_4440, 64'h0));
        wait_idle(200);
        check_span("b2b_first_span", 0, 3);
        chk(issue_log.size() == 2, "b2b_issue_count", 64'(issue_log.size()), 64'd2);
        if (issue_log.size() == 2 && done_log.size() > 0)
            chk(issue_log[1] - done_log[0] == 2, "b2b_gap",
                64'(issue_log[1] - done_log[0]), 64'd2);

        // Randomized traffic with random backpressure.
        ready_mode = 1;
        for (int i = 0; i < 30; i++) req_q.push_back(rand_req());
        wait_idle(8000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1);
    end

endmodule
